// File: rtl/btb_set_assoc.sv
// btb_set_assoc
// Set-associative branch target buffer with a 2-bit direction counter per
// entry and tree pseudo-LRU replacement. The fetch stage reads a purely
// combinational prediction for pc_f. The decode stage writes back each
// resolved branch/jump for pc_d, and the result becomes visible one cycle later.
//
// Ports
//   clk, reset      clock; synchronous active-high reset clearing all state
//   flush           invalidates every entry and clears PLRU state
//   pc_f            fetch PC to predict
//   btb_hit         a valid way of set(pc_f) matches the tag
//   pred_taken      hit and (jump or counter MSB)
//   pred_is_jump    is_jump of the hit entry, 0 on miss
//   pred_target     target of the hit entry, 0 on miss
//   pc_d            PC of the resolved control-flow instruction
//   cflow_valid     resolved branch/jump presented this cycle
//   cflow_taken     resolved direction
//   cflow_is_jump   1 = unconditional jump, 0 = conditional branch
//   cflow_target    resolved target
module btb_set_assoc #(
    parameter int SETS = 64,
    parameter int WAYS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] pc_f,
    output logic        btb_hit,
    output logic        pred_taken,
    output logic        pred_is_jump,
    output logic [31:0] pred_target,
    input  logic [31:0] pc_d,
    input  logic        cflow_valid,
    input  logic        cflow_taken,
    input  logic        cflow_is_jump,
    input  logic [31:0] cflow_target
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    // Storage is read combinationally by the fetch lookup, so it is kept in
    // flops rather than block RAM.
    logic [WAYS-1:0]  valid_reg  [SETS];
    logic [WAYS-1:0]  jump_reg   [SETS];
    logic [TAG_W-1:0] tag_reg    [SETS][WAYS];
    logic [31:0]      target_reg [SETS][WAYS];
    logic [1:0]       ctr_reg    [SETS][WAYS];
    // Tree bits {b2, b1, b0}. Only b0 is used for 2 ways, and none for 1 way.
    logic [2:0]       plru_reg   [SETS];

    logic [IDX_W-1:0] f_idx, d_idx;
    logic [TAG_W-1:0] f_tag, d_tag;

    assign f_idx = pc_f[2 +: IDX_W];
    assign f_tag = pc_f[31 -: TAG_W];
    assign d_idx = pc_d[2 +: IDX_W];
    assign d_tag = pc_d[31 -: TAG_W];

    logic [WAYS-1:0]       f_match, d_match;
    logic [WAYS-1:0][31:0] f_target_w;
    logic [WAYS-1:0][1:0]  f_ctr_w, d_ctr_w;
    logic [WAYS-1:0]       f_jump_w, d_valid_w;

    assign f_jump_w  = jump_reg[f_idx];
    assign d_valid_w = valid_reg[d_idx];

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            assign f_match[gi]    = valid_reg[f_idx][gi] && (tag_reg[f_idx][gi] == f_tag);
            assign d_match[gi]    = valid_reg[d_idx][gi] && (tag_reg[d_idx][gi] == d_tag);
            assign f_target_w[gi] = target_reg[f_idx][gi];
            assign f_ctr_w[gi]    = ctr_reg[f_idx][gi];
            assign d_ctr_w[gi]    = ctr_reg[d_idx][gi];
        end
    endgenerate

    // Prediction: scan downwards so the lowest-numbered matching way wins.
    logic [1:0] f_ctr;
    always_comb begin
        btb_hit      = 1'b0;
        pred_is_jump = 1'b0;
        pred_target  = 32'h0;
        f_ctr        = 2'b00;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (f_match[w]) begin
                btb_hit      = 1'b1;
                pred_is_jump = f_jump_w[w];
                pred_target  = f_target_w[w];
                f_ctr        = f_ctr_w[w];
            end
        end
        pred_taken = btb_hit && (pred_is_jump || f_ctr[1]);
    end

    // Update path: hit detection, victim choice, next counter and PLRU.
    logic       d_hit, inv_found, upd_en;
    logic [1:0] d_way, inv_way, plru_victim, upd_way, d_ctr, ctr_next;
    logic [2:0] plru_cur, plru_next;

    always_comb begin
        d_hit     = 1'b0;
        d_way     = 2'd0;
        d_ctr     = 2'b00;
        inv_found = 1'b0;
        inv_way   = 2'd0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (d_match[w]) begin
                d_hit = 1'b1;
                d_way = 2'(w);
                d_ctr = d_ctr_w[w];
            end
            if (!d_valid_w[w]) begin
                inv_found = 1'b1;
                inv_way   = 2'(w);
            end
        end

        plru_cur = plru_reg[d_idx];
        if (WAYS == 2)
            plru_victim = {1'b0, plru_cur[0]};
        else if (WAYS == 4)
            plru_victim = plru_cur[0] ? {1'b1, plru_cur[2]} : {1'b0, plru_cur[1]};
        else
            plru_victim = 2'd0;

        upd_way = d_hit ? d_way : (inv_found ? inv_way : plru_victim);
        // A miss only allocates when the branch was taken.
        upd_en  = cflow_valid && (d_hit || cflow_taken);

        if (!d_hit)
            ctr_next = 2'b10;
        else if (cflow_taken)
            ctr_next = (d_ctr == 2'b11) ? 2'b11 : d_ctr + 2'b01;
        else
            ctr_next = (d_ctr == 2'b00) ? 2'b00 : d_ctr - 2'b01;

        // Touch: point the tree away from the way just used.
        plru_next = plru_cur;
        if (WAYS == 2) begin
            plru_next[0] = ~upd_way[0];
        end else if (WAYS == 4) begin
            plru_next[0] = ~upd_way[1];
            if (!upd_way[1])
                plru_next[1] = ~upd_way[0];
            else
                plru_next[2] = ~upd_way[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s] <= '0;
                jump_reg[s]  <= '0;
                plru_reg[s]  <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_reg[s][w]    <= '0;
                    target_reg[s][w] <= '0;
                    ctr_reg[s][w]    <= '0;
                end
            end
        end else if (flush) begin
            // Counters and targets are deliberately left untouched.
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s] <= '0;
                plru_reg[s]  <= '0;
            end
        end else if (upd_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (upd_way == 2'(w)) begin
                    valid_reg[d_idx][w] <= 1'b1;
                    jump_reg[d_idx][w]  <= cflow_is_jump;
                    tag_reg[d_idx][w]   <= d_tag;
                    ctr_reg[d_idx][w]   <= ctr_next;
                    // Not-taken hits keep their old target.
                    if (cflow_taken)
                        target_reg[d_idx][w] <= cflow_target;
                end
            end
            plru_reg[d_idx] <= plru_next;
        end
    end

endmodule

// File: tb/tb_btb_set_assoc.sv
// Scoreboard bench for btb_set_assoc. A 2-way and a 4-way instance share
// every input. Each lookup pushes its hand-computed expectation into a
// queue, and the monitor pops and compares at the falling edge of any cycle
// flagged as a check cycle.
module tb_btb_set_assoc;

    logic        clk = 1'b0;
    logic        reset, flush, cflow_valid, cflow_taken, cflow_is_jump;
    logic [31:0] pc_f, pc_d, cflow_target;

    logic        hit2, taken2, jump2;
    logic [31:0] tgt2;
    logic        hit4, taken4, jump4;
    logic [31:0] tgt4;

    always #5 clk = ~clk;

    btb_set_assoc #(.SETS(64), .WAYS(2)) dut2 (
        .clk(clk), .reset(reset), .flush(flush), .pc_f(pc_f),
        .btb_hit(hit2), .pred_taken(taken2), .pred_is_jump(jump2), .pred_target(tgt2),
        .pc_d(pc_d), .cflow_valid(cflow_valid), .cflow_taken(cflow_taken),
        .cflow_is_jump(cflow_is_jump), .cflow_target(cflow_target)
    );

    btb_set_assoc #(.SETS(64), .WAYS(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush), .pc_f(pc_f),
        .btb_hit(hit4), .pred_taken(taken4), .pred_is_jump(jump4), .pred_target(tgt4),
        .pc_d(pc_d), .cflow_valid(cflow_valid), .cflow_taken(cflow_taken),
        .cflow_is_jump(cflow_is_jump), .cflow_target(cflow_target)
    );

    typedef struct {
        bit          d4;
        logic        hit;
        logic        taken;
        logic        jump;
        logic [31:0] tgt;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    bit   chk_valid = 1'b0;
    int   checks    = 0;
    int   failures  = 0;

    // Monitor: one comparison per flagged cycle.
    always @(negedge clk) begin
        if (chk_valid) begin
            exp_t        e;
            logic        a_hit, a_taken, a_jump;
            logic [31:0] a_tgt;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL no_expectation: check cycle with empty scoreboard");
            end else begin
                e       = exp_q.pop_front();
                a_hit   = e.d4 ? hit4   : hit2;
                a_taken = e.d4 ? taken4 : taken2;
                a_jump  = e.d4 ? jump4  : jump2;
                a_tgt   = e.d4 ? tgt4   : tgt2;
                if (a_hit !== e.hit || a_taken !== e.taken || a_jump !== e.jump || a_tgt !== e.tgt) begin
                    failures++;
                    $display("FAIL %s: got hit=%0b taken=%0b jump=%0b tgt=%h, expected hit=%0b taken=%0b jump=%0b tgt=%h",
                             e.name, a_hit, a_taken, a_jump, a_tgt, e.hit, e.taken, e.jump, e.tgt);
                end else begin
                    $display("ok   %s: hit=%0b taken=%0b jump=%0b tgt=%h",
                             e.name, a_hit, a_taken, a_jump, a_tgt);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic fl, input logic cv, input logic ct,
                         input logic cj, input logic [31:0] pd, input logic [31:0] tg,
                         input logic [31:0] pf);
        @(posedge clk);
        #1;
        reset         = r;
        flush         = fl;
        cflow_valid   = cv;
        cflow_taken   = ct;
        cflow_is_jump = cj;
        pc_d          = pd;
        cflow_target  = tg;
        pc_f          = pf;
        chk_valid     = 1'b0;
    endtask

    // Flags the current cycle as a check cycle and records its expectation.
    task automatic expect_out(input bit d4, input logic eh, input logic et, input logic ej,
                              input logic [31:0] etg, input string nm);
        exp_t e;
        e.d4 = d4; e.hit = eh; e.taken = et; e.jump = ej; e.tgt = etg; e.name = nm;
        exp_q.push_back(e);
        chk_valid = 1'b1;
    endtask

    task automatic upd(input logic [31:0] pd, input logic ct, input logic cj, input logic [31:0] tg);
        drive(1'b0, 1'b0, 1'b1, ct, cj, pd, tg, 32'h0);
    endtask

    task automatic look(input bit d4, input logic [31:0] pf, input logic eh, input logic et,
                        input logic ej, input logic [31:0] etg, input string nm);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, pf);
        expect_out(d4, eh, et, ej, etg, nm);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; cflow_valid = 1'b0; cflow_taken = 1'b0;
        cflow_is_jump = 1'b0; pc_d = '0; cflow_target = '0; pc_f = '0;

        // 1: reset state and basic allocation
        do_reset();
        look(0, 32'h100, 0, 0, 0, 32'h0, "reset_miss_w2");
        look(1, 32'h100, 0, 0, 0, 32'h0, "reset_miss_w4");
        upd(32'h100, 1, 0, 32'h400);
        look(0, 32'h100, 1, 1, 0, 32'h400, "alloc_hit");
        look(0, 32'h104, 0, 0, 0, 32'h0, "neighbour_miss");

        // 2: counter saturation (ctr starts at 2)
        upd(32'h100, 0, 0, 32'h999);
        look(0, 32'h100, 1, 0, 0, 32'h400, "nt_dec_to_1");
        upd(32'h100, 0, 0, 32'h999);
        look(0, 32'h100, 1, 0, 0, 32'h400, "nt_dec_to_0");
        upd(32'h100, 0, 0, 32'h999);
        upd(32'h100, 1, 0, 32'h440);
        look(0, 32'h100, 1, 0, 0, 32'h440, "floor_at_0");
        upd(32'h100, 1, 0, 32'h440);
        upd(32'h100, 1, 0, 32'h440);
        upd(32'h100, 1, 0, 32'h440);
        look(0, 32'h100, 1, 1, 0, 32'h440, "sat_taken");
        upd(32'h100, 0, 0, 32'h999);
        look(0, 32'h100, 1, 1, 0, 32'h440, "ceiling_at_3");

        // Jump typing: jumps predict taken regardless of counter
        upd(32'h104, 1, 1, 32'h800);
        look(0, 32'h104, 1, 1, 1, 32'h800, "jump_alloc");
        upd(32'h104, 0, 1, 32'h0);
        upd(32'h104, 0, 1, 32'h0);
        look(0, 32'h104, 1, 1, 1, 32'h800, "jump_forces_taken");
        upd(32'h104, 0, 0, 32'h0);
        look(0, 32'h104, 1, 0, 0, 32'h800, "retype_branch");

        // 3: 2-way replacement in set 0
        do_reset();
        upd(32'h100, 1, 0, 32'h1000);
        upd(32'h200, 1, 0, 32'h2000);
        upd(32'h300, 1, 0, 32'h3000);
        look(0, 32'h100, 0, 0, 0, 32'h0,    "w2_evict_way0");
        look(0, 32'h200, 1, 1, 0, 32'h2000, "w2_keep_way1");
        look(0, 32'h300, 1, 1, 0, 32'h3000, "w2_new_way0");
        upd(32'h200, 1, 0, 32'h2000);
        upd(32'h100, 1, 0, 32'h1100);
        look(0, 32'h300, 0, 0, 0, 32'h0,    "w2_evict_after_touch");
        look(0, 32'h100, 1, 1, 0, 32'h1100, "w2_realloc");
        look(0, 32'h200, 1, 1, 0, 32'h2000, "w2_touched_kept");

        // 4: 4-way tree PLRU in set 0
        do_reset();
        upd(32'h100, 1, 0, 32'h1100);
        upd(32'h200, 1, 0, 32'h1200);
        upd(32'h300, 1, 0, 32'h1300);
        upd(32'h400, 1, 0, 32'h1400);
        upd(32'h500, 1, 0, 32'h1500);
        look(1, 32'h100, 0, 0, 0, 32'h0,    "w4_fifth_evicts_way0");
        look(1, 32'h500, 1, 1, 0, 32'h1500, "w4_fifth_hit");
        look(1, 32'h200, 1, 1, 0, 32'h1200, "w4_way1_kept");
        upd(32'h500, 1, 0, 32'h1500);
        upd(32'h600, 1, 0, 32'h1600);
        look(1, 32'h300, 0, 0, 0, 32'h0,    "w4_evicts_way2");
        look(1, 32'h600, 1, 1, 0, 32'h1600, "w4_sixth_hit");
        look(1, 32'h400, 1, 1, 0, 32'h1400, "w4_way3_kept");
        look(1, 32'h500, 1, 1, 0, 32'h1500, "w4_way0_kept");

        // 5: same-cycle collision uses pre-update state
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h400, 32'h100);
        expect_out(0, 0, 0, 0, 32'h0, "collision_same_cycle");
        look(0, 32'h100, 1, 1, 0, 32'h400, "collision_next_cycle");

        // 6: precedence
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h2000, 32'h0);
        look(0, 32'h100, 0, 0, 0, 32'h0, "flush_invalidates");
        look(0, 32'h200, 0, 0, 0, 32'h0, "flush_drops_update");
        upd(32'h100, 1, 0, 32'h400);
        look(0, 32'h100, 1, 1, 0, 32'h400, "realloc_after_flush");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 32'h3000, 32'h0);
        look(0, 32'h300, 0, 0, 0, 32'h0, "reset_drops_update");
        look(0, 32'h100, 0, 0, 0, 32'h0, "reset_clears_w2");
        look(1, 32'h100, 0, 0, 0, 32'h0, "reset_clears_w4");
        upd(32'h700, 0, 0, 32'h7000);
        look(0, 32'h700, 0, 0, 0, 32'h0, "nt_miss_no_alloc");

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
